// File: rtl/apb_slave_mem_responder_if.sv
// APB completer bus bundle: requester-driven select/phase/address/data lines
// and completer-driven ready/response/read-data lines.
interface apb_slave_mem_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [2:0]                pprot;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem_responder.sv
// APB completer backed by a word-organised register memory.
// Programmable wait states (sampled at SETUP), byte-strobe writes, and
// PSLVERR for out-of-range, below-base or misaligned addresses.
module apb_slave_mem_responder #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         MEM_DEPTH     = 256,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [3:0]  cfg_wait_states,
    apb_slave_mem_responder_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int AW    = ADDRESS_WIDTH;

    // Address arithmetic is one bit wider so a paddr below BASE_ADDR shows up
    // as a set top bit instead of wrapping into a valid-looking offset.
    localparam logic [AW:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [AW:0] BYTES_EXT = (AW+1)'(BYTES);
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_STATE = 2'd1,
        ACCESS     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic                   pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [BYTES-1:0]       pstrb_q, pstrb_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   err_q, err_d;

    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

    logic [AW:0]            off;
    logic [AW:0]            idx_full;
    logic                   addr_err;
    logic                   wr_en;
    logic [MEM_DEPTH-1:0]   word_we;

    logic                   pready;
    logic                   pslverr;
    logic [DATA_WIDTH-1:0]  prdata;

    // Decode the live bus address into a word index and an error flag.
    always_comb begin
        off      = {1'b0, bus.paddr} - BASE_EXT;
        idx_full = off / BYTES_EXT;
        addr_err = off[AW] | (idx_full >= DEPTH_EXT) | ((off % BYTES_EXT) != '0);
    end

    // Next-state, transfer latching and bus response.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        idx_d      = idx_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        pready     = 1'b0;
        pslverr    = 1'b0;
        prdata     = '0;

        case (state_q)
            IDLE: begin
                // SETUP cycle; penable alone in IDLE is not a transfer.
                if (bus.psel && !bus.penable) begin
                    pwrite_d   = bus.pwrite;
                    pwdata_d   = bus.pwdata;
                    pstrb_d    = bus.pstrb;
                    idx_d      = idx_full[IDX_W-1:0];
                    err_d      = addr_err;
                    wait_cnt_d = cfg_wait_states;
                    state_d    = (cfg_wait_states != 4'd0) ? WAIT_STATE : ACCESS;
                end
            end
            WAIT_STATE: begin
                if (!bus.psel) begin
                    state_d    = IDLE;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                pready  = 1'b1;
                pslverr = err_q;
                prdata  = err_q ? '0 : mem_q[idx_q];
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (bus.penable) begin
                    state_d = IDLE;
                    wr_en   = pwrite_q & ~err_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and transfer-capture registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
        end
    end

    // One write-enable per memory word from the latched index.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = wr_en && (idx_q == IDX_W'(gi));
        end
    endgenerate

    // Memory words: cleared on reset, byte-lane writes on completion.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int w = 0; w < MEM_DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < MEM_DEPTH; w++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (word_we[w] && pstrb_q[b]) begin
                        mem_q[w][b*8 +: 8] <= pwdata_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign bus.pready  = pready;
    assign bus.pslverr = pslverr;
    assign bus.prdata  = prdata;
endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// Directed bench for apb_slave_mem_responder: a table of back-to-back
// transfers plus hand-written reset and abort sequences.
module tb_apb_slave_mem_responder;
    logic        clk;
    logic        srst;
    logic [3:0]  cfg_wait_states;

    int checks;
    int errors;

    apb_slave_mem_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_slave_mem_responder #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_DEPTH     (256),
        .BASE_ADDR     (32'h0)
    ) dut (
        .pclk            (clk),
        .preset          (srst),
        .cfg_wait_states (cfg_wait_states),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cycles;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transfer starting in the current (IDLE) cycle; returns when the
    // completing edge has passed and the bus is idle again.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [3:0] waits,
                            output logic [31:0] rdata, output logic err, output int cycles);
        int low;
        low = 0;
        bus.psel        = 1'b1;
        bus.penable     = 1'b0;
        bus.pwrite      = wr;
        bus.paddr       = addr;
        bus.pwdata      = wdata;
        bus.pstrb       = strb;
        cfg_wait_states = waits;
        cycles = 1;
        step();
        bus.penable = 1'b1;
        cycles++;
        while (bus.pready !== 1'b1 && low < 40) begin
            low++;
            check("pslverr_low_while_waiting", {31'd0, bus.pslverr}, 32'd0);
            step();
            cycles++;
        end
        if (bus.pready !== 1'b1) begin
            errors++;
            $display("FAIL timeout waiting for pready addr=0x%08h", addr);
        end
        rdata = bus.prdata;
        err   = bus.pslverr;
        step();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        cfg_wait_states = 4'd0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;

    initial begin
        checks = 0;
        errors = 0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0; bus.pprot = 3'b010;
        cfg_wait_states = 4'd0;

        //          wr    addr          wdata          strb     waits  exp_rdata      err  cycles
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF,    4'd0,  32'h0,         1'b0, 2};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF,  4'hF,    4'd0,  32'h0,         1'b0, 2};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF,    4'd0,  32'hDEADBEEF,  1'b0, 2};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h11223344,  4'b0101, 4'd0,  32'h0,         1'b0, 2};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0,    4'd0,  32'hDE22BE44,  1'b0, 2};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF,    4'd3,  32'hDE22BE44,  1'b0, 5};
        vecs[6]  = '{1'b0, 32'h0000_0400, 32'h0,         4'hF,    4'd0,  32'h0,         1'b1, 2};
        vecs[7]  = '{1'b0, 32'h0000_0013, 32'h0,         4'hF,    4'd0,  32'h0,         1'b1, 2};
        vecs[8]  = '{1'b1, 32'h0000_03FC, 32'hAABBCCDD,  4'hF,    4'd1,  32'h0,         1'b0, 3};
        vecs[9]  = '{1'b1, 32'h0000_0400, 32'hFFFFFFFF,  4'hF,    4'd2,  32'h0,         1'b1, 4};
        vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         4'hF,    4'd0,  32'hAABBCCDD,  1'b0, 2};
        vecs[11] = '{1'b1, 32'h0000_0010, 32'h55555555,  4'h0,    4'd0,  32'h0,         1'b0, 2};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF,    4'd0,  32'hDE22BE44,  1'b0, 2};
        vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF,    4'd15, 32'h0,         1'b0, 17};
        vecs[14] = '{1'b1, 32'h0000_0004, 32'h99887766,  4'b1000, 4'd2,  32'h0,         1'b0, 4};
        vecs[15] = '{1'b0, 32'h0000_0004, 32'h0,         4'hF,    4'd0,  32'h99000000,  1'b0, 2};

        srst = 1'b1;
        step();
        step();
        srst = 1'b0;
        check("reset_pready",  {31'd0, bus.pready},  32'd0);
        check("reset_pslverr", {31'd0, bus.pslverr}, 32'd0);
        check("reset_prdata",  bus.prdata,           32'd0);

        // Table: back-to-back transfers, each SETUP in the completion's IDLE cycle.
        for (int i = 0; i < NVEC; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].waits, rd, er, cyc);
            $display("vec %0d %s addr=0x%08h waits=%0d prdata=0x%08h pslverr=%0b cycles=%0d",
                     i, vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].waits, rd, er, cyc);
            if (!vecs[i].wr) check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_pslverr", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
        end

        // Reset during the wait phase of a write to 0x20.
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h20; bus.pwdata = 32'h12345678; bus.pstrb = 4'hF;
        cfg_wait_states = 4'd4;
        step();
        bus.penable = 1'b1;
        step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0; cfg_wait_states = 4'd0;
        check("rst_midwait_pready", {31'd0, bus.pready}, 32'd0);
        apb_xfer(1'b0, 32'h20, 32'h0, 4'hF, 4'd0, rd, er, cyc);
        $display("rst_midwait read 0x20 prdata=0x%08h pslverr=%0b cycles=%0d", rd, er, cyc);
        check("rst_midwait_rd20", rd, 32'h0);
        check("rst_midwait_cycles", 32'(cyc), 32'd2);
        apb_xfer(1'b0, 32'h10, 32'h0, 4'hF, 4'd0, rd, er, cyc);
        $display("rst_midwait read 0x10 prdata=0x%08h pslverr=%0b cycles=%0d", rd, er, cyc);
        check("rst_cleared_mem_rd10", rd, 32'h0);

        // psel dropped during wait states: transfer aborted, nothing written.
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h24; bus.pwdata = 32'hCAFEF00D; bus.pstrb = 4'hF;
        cfg_wait_states = 4'd3;
        step();
        bus.penable = 1'b1;
        step();
        check("abort_wait_pready", {31'd0, bus.pready}, 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0; cfg_wait_states = 4'd0;
        step();
        check("abort_idle_pready", {31'd0, bus.pready}, 32'd0);
        apb_xfer(1'b0, 32'h24, 32'h0, 4'hF, 4'd0, rd, er, cyc);
        $display("abort read 0x24 prdata=0x%08h pslverr=%0b cycles=%0d", rd, er, cyc);
        check("abort_rd24", rd, 32'h0);
        check("abort_rd24_err", {31'd0, er}, 32'd0);

        // penable without a SETUP cycle must not start a transfer.
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = 32'h10;
        step();
        check("penable_in_idle_pready", {31'd0, bus.pready}, 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
